// File: rtl/dac_spi_arbiter_pkg.sv
// dac_spi_arbiter shared package
// Owner encoding, FSM states and widths for the bias-DAC SPI arbiter.
package dac_pkg;

    localparam int DAC_W = 8;
    localparam int TMR_W = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CAL  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GUARD
    } state_t;

endpackage

// File: rtl/dac_spi_arbiter_if.sv
// dac_spi_arbiter requester / SPI bundle
// slave = arbiter side, master = calibration, host and SPI side.
interface dac_spi_arbiter_if;

    logic                      cal_req;
    logic [dac_pkg::DAC_W-1:0] cal_data;
    logic                      cal_ack;
    logic                      cal_done;
    logic                      host_req;
    logic [dac_pkg::DAC_W-1:0] host_data;
    logic                      host_ack;
    logic                      host_done;
    logic                      spi_start;
    logic [dac_pkg::DAC_W-1:0] spi_data;
    logic                      spi_done;
    logic [1:0]                owner;
    logic [dac_pkg::DAC_W-1:0] dac_value;
    logic                      timeout_err;

    modport slave (
        input  cal_req, cal_data, host_req, host_data, spi_done,
        output cal_ack, cal_done, host_ack, host_done,
        output spi_start, spi_data, owner, dac_value, timeout_err
    );

    modport master (
        output cal_req, cal_data, host_req, host_data, spi_done,
        input  cal_ack, cal_done, host_ack, host_done,
        input  spi_start, spi_data, owner, dac_value, timeout_err
    );

endinterface

// File: rtl/dac_spi_arbiter_timer.sv
// arb_timeout_timer: 16-bit counter with clear, enable and terminal compare
// Shared between the SPI timeout window and the inter-frame guard.
module arb_timeout_timer
    import dac_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] term,
    output logic             tc
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Clear wins over count so a new window always starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one SPI bias-DAC master between cal and host.
// Optional ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests.
module dac_spi_arbiter
    import dac_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int TIMEOUT_US   = 40,
    parameter int GUARD_TICKS  = 4
) (
    input logic              clk,
    input logic              reset_n,
    dac_spi_arbiter_if.slave bus
);

    localparam int TIMEOUT_TICKS = CLK_FREQ_MHZ * TIMEOUT_US;

    generate
        if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS >= 65536) begin : g_tmo_chk
            $error("TIMEOUT_TICKS must fit the 16-bit timer");
        end
        if (GUARD_TICKS < 1 || GUARD_TICKS >= 65536) begin : g_grd_chk
            $error("GUARD_TICKS must fit the 16-bit timer");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [DAC_W-1:0]   spi_data_q, spi_data_d;
    logic [DAC_W-1:0]   dac_value_q, dac_value_d;
    logic [1:0]         owner_q, owner_d;
    logic               terr_q, terr_d;
    logic               cal_ack_q, cal_ack_d;
    logic               host_ack_q, host_ack_d;
    logic               cal_done_q, cal_done_d;
    logic               host_done_q, host_done_d;
    logic               spi_start_q, spi_start_d;

    logic               prefer_host;
    logic               pick_host;
    logic               pick_cal;

    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_tc;
    logic [TMR_W-1:0]   tmr_term;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = host won the last grant, so calibration is preferred next time.
    logic last_winner_q, last_winner_d;

    // Remember who was served last.
    always_comb begin
        last_winner_d = last_winner_q;
        if (state_q == IDLE && (pick_host || pick_cal)) begin
            last_winner_d = pick_host;
        end
    end

    // Priority memory register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_q <= 1'b0;
        end else begin
            last_winner_q <= last_winner_d;
        end
    end

    assign prefer_host = ~last_winner_q;
`else
    assign prefer_host = 1'b1;
`endif

    assign pick_host = bus.host_req & (~bus.cal_req | prefer_host);
    assign pick_cal  = bus.cal_req & ~pick_host;

    assign tmr_term = (state_q == GUARD) ? TMR_W'(GUARD_TICKS - 1)
                                         : TMR_W'(TIMEOUT_TICKS - 1);

    arb_timeout_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .term    (tmr_term),
        .tc      (tmr_tc)
    );

    // Arbitration FSM: grant, start frame, wait for done/timeout, guard.
    always_comb begin
        state_d     = state_q;
        spi_data_d  = spi_data_q;
        dac_value_d = dac_value_q;
        owner_d     = owner_q;
        terr_d      = terr_q;
        cal_ack_d   = 1'b0;
        host_ack_d  = 1'b0;
        cal_done_d  = 1'b0;
        host_done_d = 1'b0;
        spi_start_d = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_host) begin
                    spi_data_d = bus.host_data;
                    owner_d    = OWN_HOST;
                    host_ack_d = 1'b1;
                    state_d    = START;
                end else if (pick_cal) begin
                    spi_data_d = bus.cal_data;
                    owner_d    = OWN_CAL;
                    cal_ack_d  = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                spi_start_d = 1'b1;
                tmr_clr     = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                tmr_en = 1'b1;
                if (bus.spi_done || tmr_tc) begin
                    if (bus.spi_done) begin
                        dac_value_d = spi_data_q;
                    end else begin
                        terr_d = 1'b1;
                    end
                    host_done_d = (owner_q == OWN_HOST);
                    cal_done_d  = (owner_q == OWN_CAL);
                    tmr_clr     = 1'b1;
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                owner_d = OWN_NONE;
                tmr_en  = 1'b1;
                if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            spi_data_q  <= '0;
            dac_value_q <= '0;
            owner_q     <= OWN_NONE;
            terr_q      <= 1'b0;
            cal_ack_q   <= 1'b0;
            host_ack_q  <= 1'b0;
            cal_done_q  <= 1'b0;
            host_done_q <= 1'b0;
            spi_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            spi_data_q  <= spi_data_d;
            dac_value_q <= dac_value_d;
            owner_q     <= owner_d;
            terr_q      <= terr_d;
            cal_ack_q   <= cal_ack_d;
            host_ack_q  <= host_ack_d;
            cal_done_q  <= cal_done_d;
            host_done_q <= host_done_d;
            spi_start_q <= spi_start_d;
        end
    end

    assign bus.cal_ack     = cal_ack_q;
    assign bus.host_ack    = host_ack_q;
    assign bus.cal_done    = cal_done_q;
    assign bus.host_done   = host_done_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.spi_data    = spi_data_q;
    assign bus.owner       = owner_q;
    assign bus.dac_value   = dac_value_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb_dac_spi_arbiter: directed bench for the DAC SPI arbiter
// Default build (fixed host-over-calibration priority).
module tb_dac_spi_arbiter;
    import dac_pkg::*;

    localparam int T = 2000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    dac_spi_arbiter_if bus();

    dac_spi_arbiter u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return bus.spi_start;
            1:       return bus.host_done;
            2:       return bus.cal_done;
            default: return bus.cal_ack;
        endcase
    endfunction

    // Waits (bounded) for a signal at negedges; n = negedges taken.
    task automatic wait_sig(input int w, input int budget, input string tag,
                            output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel(w) && n < budget);
        check(tag, 32'(sel(w)), 1);
    endtask

    function automatic int pulses_now();
        return int'(bus.cal_ack) + int'(bus.host_ack) + int'(bus.cal_done)
             + int'(bus.host_done) + int'(bus.spi_start);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        bus.cal_req   = 1'b0;
        bus.cal_data  = '0;
        bus.host_req  = 1'b0;
        bus.host_data = '0;
        bus.spi_done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_owner", bus.owner, OWN_NONE);
        check("rst_spi_data", bus.spi_data, 0);
        check("rst_dac", bus.dac_value, 0);
        check("rst_terr", bus.timeout_err, 0);
        check("rst_pulses", pulses_now(), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single calibration write
        bus.cal_req  = 1'b1;
        bus.cal_data = 8'h10;
        @(negedge clk);
        check("t1_cal_ack", bus.cal_ack, 1);
        check("t1_owner", bus.owner, OWN_CAL);
        check("t1_spi_data", bus.spi_data, 8'h10);
        check("t1_start_early", bus.spi_start, 0);
        bus.cal_req = 1'b0;
        wait_sig(0, 4, "t1_spi_start", n);
        check("t1_latency", n, 1);
        repeat (99) @(negedge clk);
        check("t1_no_early_done", bus.cal_done, 0);
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check("t1_cal_done", bus.cal_done, 1);
        check("t1_dac", bus.dac_value, 8'h10);
        check("t1_owner_at_done", bus.owner, OWN_CAL);
        @(negedge clk);
        check("t1_owner_clr", bus.owner, OWN_NONE);
        check("t1_done_pulse", bus.cal_done, 0);
        repeat (5) @(negedge clk);

        // 2: simultaneous requests, host first
        bus.cal_req   = 1'b1;
        bus.cal_data  = 8'h20;
        bus.host_req  = 1'b1;
        bus.host_data = 8'hA5;
        @(negedge clk);
        check("t2_host_ack", bus.host_ack, 1);
        check("t2_cal_ack0", bus.cal_ack, 0);
        check("t2_spi_data", bus.spi_data, 8'hA5);
        check("t2_owner", bus.owner, OWN_HOST);
        bus.host_req = 1'b0;
        wait_sig(0, 4, "t2_host_start", n);
        repeat (5) @(negedge clk);
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check("t2_host_done", bus.host_done, 1);
        check("t2_dac_a5", bus.dac_value, 8'hA5);
        wait_sig(3, 10, "t2_cal_ack", n);
        check("t2_guard_gap", n, 5);
        check("t2_cal_data", bus.spi_data, 8'h20);
        check("t2_cal_owner", bus.owner, OWN_CAL);
        bus.cal_req = 1'b0;
        wait_sig(0, 4, "t2_cal_start", n);
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check("t2_cal_done", bus.cal_done, 1);
        check("t2_dac_20", bus.dac_value, 8'h20);
        repeat (5) @(negedge clk);

        // 3: host write that times out
        bus.host_req  = 1'b1;
        bus.host_data = 8'h33;
        @(negedge clk);
        check("t3_host_ack", bus.host_ack, 1);
        bus.host_req = 1'b0;
        wait_sig(0, 4, "t3_start", n);
        wait_sig(1, T + 50, "t3_host_done", n);
        check("t3_timeout_len", n, T);
        check("t3_terr", bus.timeout_err, 1);
        check("t3_dac_kept", bus.dac_value, 8'h20);
        repeat (8) @(negedge clk);
        check("t3_terr_sticky", bus.timeout_err, 1);

        // 5: reset during WAIT_DONE
        bus.host_req  = 1'b1;
        bus.host_data = 8'h44;
        @(negedge clk);
        bus.host_req = 1'b0;
        wait_sig(0, 4, "t5_start", n);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_owner", bus.owner, OWN_NONE);
        check("t5_spi_data", bus.spi_data, 0);
        check("t5_dac", bus.dac_value, 0);
        check("t5_terr", bus.timeout_err, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += pulses_now();
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            pulses += pulses_now();
        end
        check("t5_no_pulses", pulses, 0);

        // 4: spi_done on the terminal timeout clock
        bus.cal_req  = 1'b1;
        bus.cal_data = 8'h5A;
        @(negedge clk);
        check("t4_cal_ack", bus.cal_ack, 1);
        bus.cal_req = 1'b0;
        wait_sig(0, 4, "t4_start", n);
        repeat (T - 1) @(negedge clk);
        check("t4_no_early_done", bus.cal_done, 0);
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check("t4_cal_done", bus.cal_done, 1);
        check("t4_dac", bus.dac_value, 8'h5A);
        check("t4_terr0", bus.timeout_err, 0);
        repeat (5) @(negedge clk);

        // 6: stray spi_done and early-dropped request
        bus.host_req  = 1'b1;
        bus.host_data = 8'h77;
        @(negedge clk);
        bus.host_req = 1'b0;
        wait_sig(0, 4, "t6_start", n);
        repeat (3) @(negedge clk);
        bus.spi_done = 1'b1;
        @(negedge clk);
        check("t6_host_done", bus.host_done, 1);
        check("t6_dac", bus.dac_value, 8'h77);
        bus.cal_req  = 1'b1;
        bus.cal_data = 8'hEE;
        pulses = 0;
        @(negedge clk);
        bus.spi_done = 1'b0;
        pulses += pulses_now();
        check("t6_owner_guard", bus.owner, OWN_NONE);
        @(negedge clk);
        bus.cal_req = 1'b0;
        pulses += pulses_now();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += pulses_now();
            bus.spi_done = (i == 4);
        end
        bus.spi_done = 1'b0;
        @(negedge clk);
        pulses += pulses_now();
        check("t6_no_pulses", pulses, 0);
        check("t6_dac_kept", bus.dac_value, 8'h77);
        check("t6_owner_idle", bus.owner, OWN_NONE);
        check("t6_terr0", bus.timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
